// File: rtl/eth_sw_pkg.sv
// Shared types for the switch egress path: buffer words, buffer entries and the
// transmit/write state encodings.
package eth_sw_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t data;
        logic  sop;
        logic  eop;
    } buf_entry_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PKT  = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/eth_port_tx_if.sv
// Fabric write bus plus egress stream of one switch port; the fabric/bench side
// uses the master modport, the transmitter uses the slave modport.
interface eth_port_tx_if #(parameter int DEPTH = 16);
    import eth_sw_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    word_t          inData;
    logic           inSop;
    logic           inEop;
    logic           inValid;
    logic           inReady;
    word_t          outData;
    logic           outSop;
    logic           outEop;
    logic           portStall;
    logic           pktDropped;
    logic [CW-1:0]  pktCount;

    modport master (
        output inData, inSop, inEop, inValid, portStall,
        input  inReady, outData, outSop, outEop, pktDropped, pktCount
    );

    modport slave (
        input  inData, inSop, inEop, inValid, portStall,
        output inReady, outData, outSop, outEop, pktDropped, pktCount
    );

endinterface

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward buffer with a speculative write pointer, a commit pointer
// that bounds what the reader may see, and a rewind to drop a partial packet.
module eth_pkt_fifo
    import eth_sw_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       push,
    input  buf_entry_t                 push_entry,
    input  logic                       rewind,
    input  logic                       commit,
    input  logic                       pop,
    output buf_entry_t                 rd_entry,
    output logic                       full_nxt,
    output logic [$clog2(DEPTH):0]     uncommitted
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = AW + 1;

    buf_entry_t     mem_q [DEPTH];
    logic [W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   wr_base;

    // Rewind restarts the write at the last commit point before any push lands.
    always_comb begin
        wr_base      = rewind ? commit_ptr_q : wr_ptr_q;
        wr_ptr_d     = wr_base + {{(W-1){1'b0}}, push};
        commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + {{(W-1){1'b0}}, pop};
        full_nxt     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        uncommitted  = wr_ptr_q - commit_ptr_q;
        rd_entry     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q     <= {W{1'b0}};
            commit_ptr_q <= {W{1'b0}};
            rd_ptr_q     <= {W{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless until covered by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_base[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/eth_port_tx.sv
// Egress transmitter: frames fabric words into the packet buffer, drops malformed
// or oversize packets, and replays complete packets as contiguous bursts.
module eth_port_tx
    import eth_sw_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IPG   = 1
) (
    input  logic          clk,
    input  logic          resetN,
    eth_port_tx_if.slave  bus
);

    localparam int              W         = $clog2(DEPTH) + 1;
    localparam logic [W-1:0]    LAST_FREE = W'(DEPTH - 1);
    localparam logic [2:0]      GAP_LAST  = (IPG > 0) ? 3'(IPG - 1) : 3'd0;
    localparam bit              HAS_GAP   = (IPG > 0);

    wr_state_e      wr_state_q, wr_state_d;
    tx_state_e      tx_state_q, tx_state_d;
    logic [2:0]     gap_q, gap_d;
    logic [W-1:0]   pkt_count_q, pkt_count_d;
    logic           in_ready_q, in_ready_d;
    logic           drop_q, drop_d;
    word_t          out_data_q, out_data_d;
    logic           out_sop_q, out_sop_d;
    logic           out_eop_q, out_eop_d;

    logic           push, rewind, commit, pop, inc, dec, full_nxt;
    buf_entry_t     push_entry, rd_entry;
    logic [W-1:0]   uncommitted;

    eth_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetN      (resetN),
        .push        (push),
        .push_entry  (push_entry),
        .rewind      (rewind),
        .commit      (commit),
        .pop         (pop),
        .rd_entry    (rd_entry),
        .full_nxt    (full_nxt),
        .uncommitted (uncommitted)
    );

    // Write framing: accept, restart, drop or commit each accepted fabric word.
    always_comb begin
        push       = 1'b0;
        rewind     = 1'b0;
        commit     = 1'b0;
        inc        = 1'b0;
        drop_d     = 1'b0;
        wr_state_d = wr_state_q;
        push_entry = '{data: bus.inData, sop: bus.inSop, eop: bus.inEop};
        if (bus.inValid && in_ready_q) begin
            case (wr_state_q)
                WR_DROP: begin
                    if (bus.inEop) begin
                        wr_state_d = WR_IDLE;
                    end else begin
                        wr_state_d = WR_DROP;
                    end
                end
                WR_IDLE, WR_PKT: begin
                    if (bus.inSop) begin
                        push       = 1'b1;
                        rewind     = (wr_state_q == WR_PKT);
                        drop_d     = (wr_state_q == WR_PKT);
                        commit     = bus.inEop;
                        inc        = bus.inEop;
                        wr_state_d = bus.inEop ? WR_IDLE : WR_PKT;
                    end else if (wr_state_q == WR_IDLE) begin
                        drop_d = 1'b1;
                    end else if (bus.inEop) begin
                        push       = 1'b1;
                        commit     = 1'b1;
                        inc        = 1'b1;
                        wr_state_d = WR_IDLE;
                    end else if (uncommitted == LAST_FREE) begin
                        // Packet can never fit: discard it and swallow the rest.
                        rewind     = 1'b1;
                        drop_d     = 1'b1;
                        wr_state_d = WR_DROP;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end else begin
            wr_state_d = wr_state_q;
        end
        in_ready_d = (wr_state_d == WR_DROP) || !full_nxt;
    end

    // Transmit FSM: stall only gates the start of a packet, never its middle.
    always_comb begin
        tx_state_d = tx_state_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        dec        = 1'b0;
        out_data_d = 32'h0000_0000;
        out_sop_d  = 1'b0;
        out_eop_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE, TX_SEND: begin
                if ((tx_state_q == TX_SEND) ||
                    ((pkt_count_q != {W{1'b0}}) && !bus.portStall)) begin
                    pop        = 1'b1;
                    out_data_d = rd_entry.data;
                    out_sop_d  = rd_entry.sop;
                    out_eop_d  = rd_entry.eop;
                    gap_d      = 3'd0;
                    if (rd_entry.eop) begin
                        dec        = 1'b1;
                        tx_state_d = HAS_GAP ? TX_GAP : TX_IDLE;
                    end else begin
                        tx_state_d = TX_SEND;
                    end
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d      = 3'd0;
                    tx_state_d = TX_IDLE;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        pkt_count_d = pkt_count_q + {{(W-1){1'b0}}, inc} - {{(W-1){1'b0}}, dec};
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_state_q  <= WR_IDLE;
            tx_state_q  <= TX_IDLE;
            gap_q       <= 3'd0;
            pkt_count_q <= {W{1'b0}};
            in_ready_q  <= 1'b0;
            drop_q      <= 1'b0;
            out_data_q  <= 32'h0000_0000;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            tx_state_q  <= tx_state_d;
            gap_q       <= gap_d;
            pkt_count_q <= pkt_count_d;
            in_ready_q  <= in_ready_d;
            drop_q      <= drop_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign bus.inReady    = in_ready_q;
    assign bus.pktDropped = drop_q;
    assign bus.pktCount   = pkt_count_q;
    assign bus.outData    = out_data_q;
    assign bus.outSop     = out_sop_q;
    assign bus.outEop     = out_eop_q;

endmodule

// File: tb/tb_eth_port_tx.sv
// Scoreboard bench for eth_port_tx: kept packets are queued as they are written
// and popped against every egress beat.
module tb_eth_port_tx;
    import eth_sw_pkg::*;

    localparam int DEPTH = 16;
    localparam int IPG   = 1;

    logic clk;
    logic resetN;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   beats    = 0;
    int   drop_cnt = 0;
    bit   in_burst = 1'b0;
    bit   gap_pending = 1'b0;
    buf_entry_t exp_q[$];

    eth_port_tx_if #(.DEPTH(DEPTH)) bus ();

    eth_port_tx #(.DEPTH(DEPTH), .IPG(IPG)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Egress monitor: compares beats against the scoreboard and checks the gap.
    always @(negedge clk) begin
        buf_entry_t e;
        if (!resetN) begin
            in_burst    = 1'b0;
            gap_pending = 1'b0;
        end else begin
            if (bus.pktDropped) drop_cnt++;
            if (gap_pending) begin
                check_eq("ipg_gap", {63'd0, bus.outSop}, 64'd0);
                gap_pending = 1'b0;
            end
            if (bus.outSop || in_burst) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check_eq("unexp_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", {32'd0, bus.outData}, {32'd0, e.data});
                    check_eq("beat_sop", {63'd0, bus.outSop}, {63'd0, e.sop});
                    check_eq("beat_eop", {63'd0, bus.outEop}, {63'd0, e.eop});
                end
                in_burst    = !bus.outEop;
                gap_pending = bus.outEop;
            end else begin
                check_eq("idle_out", {31'd0, bus.outEop, bus.outData}, 64'd0);
            end
        end
    end

    task automatic put(input logic [31:0] d, input logic s, input logic e);
        int guard;
        bus.inData  = d;
        bus.inSop   = s;
        bus.inEop   = e;
        bus.inValid = 1'b1;
        guard = 0;
        while (!bus.inReady && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check_eq("put_timeout", 64'(guard), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.inValid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input bit keep, input bit rnd);
        buf_entry_t e;
        for (int i = 0; i < len; i++) begin
            e.data = rnd ? ($urandom() | 32'h1) : 32'(base * 32'(i + 1));
            e.sop  = (i == 0);
            e.eop  = (i == len - 1);
            if (keep) exp_q.push_back(e);
            put(e.data, e.sop, e.eop);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || in_burst) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) check_eq("drain_timeout", 64'(g), 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int b0;
        int d0;
        int g;
        buf_entry_t e;
        bus.inData    = 32'h0;
        bus.inSop     = 1'b0;
        bus.inEop     = 1'b0;
        bus.inValid   = 1'b0;
        bus.portStall = 1'b0;
        resetN        = 1'b0;
        #3;
        check_eq("rst_ready", {63'd0, bus.inReady}, 64'd0);
        check_eq("rst_out", {30'd0, bus.outSop, bus.outEop, bus.outData}, 64'd0);
        check_eq("rst_count", 64'(bus.pktCount), 64'd0);
        check_eq("rst_drop", {63'd0, bus.pktDropped}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", {63'd0, bus.inReady}, 64'd1);

        // 4-word packet and first-beat latency
        send_pkt(4, 32'h11, 1'b1, 1'b0);
        check_eq("lat_pre_sop", {63'd0, bus.outSop}, 64'd0);
        check_eq("count_one", 64'(bus.pktCount), 64'd1);
        @(negedge clk);
        check_eq("lat_sop", {63'd0, bus.outSop}, 64'd1);
        check_eq("lat_data", {32'd0, bus.outData}, 64'h11);
        wait_drain();
        check_eq("count_zero_1", 64'(bus.pktCount), 64'd0);

        // single-word packet
        send_pkt(1, 32'hAA, 1'b1, 1'b0);
        wait_drain();

        // stalled accumulation of three packets
        bus.portStall = 1'b1;
        b0 = beats;
        send_pkt(3, 32'h100, 1'b1, 1'b0);
        send_pkt(2, 32'h200, 1'b1, 1'b0);
        send_pkt(5, 32'h300, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("stall_no_out", 64'(beats - b0), 64'd0);
        check_eq("stall_count", 64'(bus.pktCount), 64'd3);
        bus.portStall = 1'b0;
        wait_drain();
        check_eq("stall_beats", 64'(beats - b0), 64'd10);
        check_eq("count_zero_3", 64'(bus.pktCount), 64'd0);

        // SOP inside a packet, then a stray non-SOP word
        d0 = drop_cnt;
        put(32'h501, 1'b1, 1'b0);
        put(32'h502, 1'b0, 1'b0);
        send_pkt(3, 32'h600, 1'b1, 1'b0);
        put(32'h777, 1'b0, 1'b1);
        wait_drain();
        check_eq("framing_drops", 64'(drop_cnt - d0), 64'd2);

        // oversize packet followed by a good one
        d0 = drop_cnt;
        b0 = beats;
        send_pkt(20, 32'h40, 1'b0, 1'b0);
        check_eq("oversize_drop", 64'(drop_cnt - d0), 64'd1);
        send_pkt(3, 32'h900, 1'b1, 1'b0);
        wait_drain();
        check_eq("oversize_beats", 64'(beats - b0), 64'd3);
        check_eq("count_zero_5", 64'(bus.pktCount), 64'd0);

        // fill exactly to full while stalled
        bus.portStall = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt(4, 32'h1000 * (p + 1), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e.data = 32'hF00 + 32'(i);
            e.sop  = (i == 0);
            e.eop  = (i == 3);
            exp_q.push_back(e);
            put(e.data, e.sop, e.eop);
            if (i == 2) check_eq("ready_at_15", {63'd0, bus.inReady}, 64'd1);
            if (i == 3) check_eq("full_at_16", {63'd0, bus.inReady}, 64'd0);
        end
        check_eq("full_count", 64'(bus.pktCount), 64'd4);
        bus.portStall = 1'b0;
        wait_drain();
        check_eq("ready_after_drain", {63'd0, bus.inReady}, 64'd1);

        // random packets to wrap the pointers many times
        for (int p = 0; p < 50; p++) send_pkt($urandom_range(1, 7), 32'h0, 1'b1, 1'b1);
        wait_drain();
        check_eq("count_zero_rnd", 64'(bus.pktCount), 64'd0);

        // reset in the middle of a burst
        send_pkt(6, 32'h2000, 1'b1, 1'b0);
        g = 0;
        while (!bus.outSop && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_eq("sop_before_rst", {63'd0, bus.outSop}, 64'd1);
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("midrst_out", {30'd0, bus.outSop, bus.outEop, bus.outData}, 64'd0);
        check_eq("midrst_count", 64'(bus.pktCount), 64'd0);
        check_eq("midrst_ready", {63'd0, bus.inReady}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check_eq("ready_after_midrst", {63'd0, bus.inReady}, 64'd1);
        send_pkt(2, 32'h3000, 1'b1, 1'b0);
        wait_drain();
        check_eq("count_zero_end", 64'(bus.pktCount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_port_tx.md
Name: eth_port_tx

Overview:
Egress transmitter for one switch port (A or B), producing the outDataX/outSopX/outEopX stream that the switch_intf monitor observes. The switch fabric writes packet words with SOP/EOP framing into an internal store-and-forward buffer. Complete packets are replayed on the port as contiguous SOP..EOP bursts. The port's portXStall backpressure is honoured at packet boundaries.

Parameters:
DEPTH, 16, buffer depth in 32-bit words (power of 2, >= 4)
IPG, 1, idle cycles forced after every EOP (0..7)

Ports:
clk  in  1  port clock
resetN  in  1  asynchronous active-low reset
inData  in  32  fabric word
inSop  in  1  first word of packet
inEop  in  1  last word of packet
inValid  in  1  word valid this cycle
inReady  out  1  buffer accepts word (handshake: inValid && inReady at posedge)
outData  out  32  egress word
outSop  out  1  egress start-of-packet
outEop  out  1  egress end-of-packet
portStall  in  1  egress backpressure
pktDropped  out  1  one-cycle pulse when a packet is discarded
pktCount  out  $clog2(DEPTH)+1  number of complete packets buffered

Behaviour:
- Reset (async assert, sync deassert): outData=0, outSop=0, outEop=0, inReady=0, pktDropped=0, pktCount=0, all pointers 0, FSM=IDLE. inReady rises the first edge after resetN high. Reset mid-packet discards all buffered data.
- Write side keeps wrPtr (speculative) and commitPtr. The read side only sees words below commitPtr.
- Accepted word with inSop starts a packet and sets inPkt=1. Accepted word with inEop: commitPtr<=wrPtr+1, pktCount++, inPkt=0. A SOP+EOP word in one beat is a 1-word packet.
- Framing errors:
  - Word without inSop while !inPkt: word discarded, pktDropped pulses.
  - inSop while inPkt: wrPtr rewinds to commitPtr, the new packet starts at commitPtr, pktDropped pulses.
- inReady = buffer not full (free = DEPTH - (wrPtr - rdPtr)).
- Oversize: if the uncommitted length reaches DEPTH, wrPtr rewinds to commitPtr and the block enters DROP mode. In DROP mode inReady=1 and words are discarded through EOP. pktDropped pulses once, on entry.
- Pointers are $clog2(DEPTH)+1 bits wide. Wrap uses the MSB toggle; full = MSBs differ and LSBs equal.
- TX FSM:
  - IDLE: if pktCount>0 && !portStall, next edge -> SEND and emit the first word with outSop=1.
  - SEND: one word per edge, contiguous, no gaps. portStall is ignored mid-packet.
  - On the edge that emits the EOP word: pktCount--, go to GAP (IPG>0) or IDLE (IPG=0).
  - GAP: count IPG cycles, then IDLE.
- Outside SEND, outSop, outEop and outData are 0. outSop and outEop are asserted on the same word for 1-word packets.
- Output timing: all outputs are registered. Latency from the EOP-accept edge E to outSop is edge E+1 (assuming IDLE and no stall).
- Simultaneous pktCount increment and decrement on one edge: net unchanged.
- portStall is sampled only in IDLE. While stalled, packets accumulate and inReady stays governed by space.

Decomposition:
- Package eth_sw_pkg holds:
  - word_t (32-bit)
  - buffer entry struct {data, sop, eop}
  - tx_state_e {IDLE, SEND, GAP}
  - DROP/inPkt write-state enum
- Sub-module eth_pkt_fifo: dual-pointer buffer with commit/rewind, the full flag and read port.
- eth_port_tx holds the write framing logic, the TX FSM and the IPG counter.

Test Plan:
- Reset, then one 4-word packet (0x11,0x22,0x33,0x44) with stall=0 -> outSop with 0x11 one edge after EOP accept; 4 contiguous words; outEop with 0x44; pktCount returns to 0; 1 idle cycle before any next SOP.
- 1-word packet (inSop=inEop=1, 0xAA) -> single out beat with outSop=outEop=1, data 0xAA.
- portStall=1 while 3 packets are written (3, 2, 5 words) -> no output, pktCount=3. Release stall -> 3 bursts in order, each separated by IPG=1 idle.
- SOP while inPkt after 2 words of packet X, then full packet Y -> pktDropped one pulse; only Y emitted.
- 20-word packet with DEPTH=16 -> pktDropped once, nothing emitted, next valid packet passes intact.
- Fill to full (stall=1) -> inReady=0 exactly at 16 words. Release stall -> inReady reasserts; pointer wrap is exercised with byte-exact data over 50 random packets; resetN pulsed mid-SEND -> outputs 0 immediately.
